fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 8, is the instruction buffer depth in 32-bit words; it SHALL be a power of two and at least 4.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  one-cycle read request strobe to memory.
REQ-006 mem_address  output  32  byte address of the first word of the request.
REQ-007 mem_access_size  output  2  burst length code: 00=1, 01=4, 10=8, 11=16 words.
REQ-008 mem_rw  output  1  tied to 0 (read only).
REQ-009 mem_busy  input  1  memory servicing a request; high for exactly N cycles after an accepted request.
REQ-010 mem_data_out  input  32  one response word per cycle while mem_busy is high, in ascending address order.
REQ-011 redirect_valid  input  1  branch/jump redirect strobe.
REQ-012 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored.
REQ-013 inst_valid  output  1  inst_data and inst_pc hold a valid instruction.
REQ-014 inst_ready  input  1  downstream accepts; transfer occurs when inst_valid and inst_ready are both high.
REQ-015 inst_data  output  32  instruction word.
REQ-016 inst_pc  output  32  byte address of inst_data.

Function
REQ-017 States: IDLE, RESP, DRAIN.
REQ-018 IDLE: mem_req SHALL assert when mem_busy is low and free FIFO slots minus reserved slots are at least the burst length N; the FSM then enters RESP.
REQ-019 A request SHALL reserve N FIFO slots, so no accepted response word is ever dropped for lack of space.
REQ-020 RESP: each cycle mem_busy is high, the FIFO SHALL write {fetch_pc, mem_data_out} and fetch_pc SHALL advance by 4.
REQ-021 RESP SHALL return to IDLE on the cycle after the Nth word.
REQ-022 Request latency: the first word is accepted in the cycle after mem_req; back-to-back requests SHALL have at least one IDLE cycle between them.
REQ-023 redirect_valid SHALL flush the FIFO, clear reservations, deassert inst_valid in the next cycle, and load fetch_pc with {redirect_pc[31:2], 2'b00}.
REQ-024 A redirect in RESP SHALL move the FSM to DRAIN, which discards remaining words of the old burst until mem_busy falls and then returns to IDLE.
REQ-025 A redirect in the same cycle as an inst transfer SHALL let that transfer complete, then flush.
REQ-026 A redirect in the same cycle as mem_req SHALL suppress mem_req.
REQ-027 A simultaneous FIFO write and read SHALL keep the occupancy constant; the FIFO full and empty flags SHALL never both assert.
REQ-028 fetch_pc SHALL wrap modulo 2^32 from 32'hFFFF_FFFC to 0.
REQ-029 inst_valid SHALL be high exactly when the FIFO is non-empty; inst_data and inst_pc SHALL show the FIFO head.

Reset
REQ-030 While reset_n is low: FSM=IDLE, fetch_pc=RESET_PC, FIFO empty, reservations=0, mem_req=0, inst_valid=0, mem_address=0, mem_access_size=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst.
REQ-032 The first mem_req after reset deassertion SHALL occur no earlier than the second rising edge and only with mem_busy low.

Configuration
REQ-033 With macro FETCH_BURST_EN defined: N=4 and mem_access_size=2'b01.
REQ-034 Without FETCH_BURST_EN: N=1 and mem_access_size=2'b00; all other behaviour SHALL be unchanged.

Structure
REQ-035 The shared package mips_pkg SHALL hold the access_size encodings, the FSM state typedef, and the word width constant.
REQ-036 The instruction buffer SHALL be a sub-module fetch_fifo: parameterised depth, 64-bit entries {pc, data}, flush input, and count output.

Verification
REQ-037 Reset release with RESET_PC=0x00400000 and burst enabled -> mem_req with address 0x00400000 and size 01; four words delivered give inst_pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-038 inst_ready held low, FIFO_DEPTH=8 -> exactly two bursts issued, then mem_req stays low; raising inst_ready for 4 transfers -> one new burst.
REQ-039 redirect_pc=0x00001002 during the 2nd response word -> remaining 2 words discarded, next mem_req address 0x00001000, first inst_pc 0x00001000.
REQ-040 fetch_pc=0xFFFFFFF8 with burst enabled -> inst_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-041 reset_n pulsed low mid-burst -> all outputs return to their reset values asynchronously, and fetch restarts at RESET_PC.
REQ-042 FETCH_BURST_EN undefined, inst_ready=1 -> size 00 requests, one instruction per two cycles, no losses.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
// Define FETCH_BURST_EN for 4-word bursts; otherwise single-word fetches.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ACC_1  = 2'b00,
        ACC_4  = 2'b01,
        ACC_8  = 2'b10,
        ACC_16 = 2'b11
    } access_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RESP  = 2'b01,
        DRAIN = 2'b10
    } fetch_state_e;

`ifdef FETCH_BURST_EN
    localparam int           BURST_LEN  = 4;
    localparam access_size_e FETCH_SIZE = ACC_4;
`else
    localparam int           BURST_LEN  = 1;
    localparam access_size_e FETCH_SIZE = ACC_1;
`endif

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, data} pairs.
// Pointers carry an extra wrap bit so full and empty stay distinct.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [2*WORD_W-1:0]     wr_data,
    input  logic                    rd_en,
    output logic [2*WORD_W-1:0]     rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] FULL_C  = (AW+1)'(DEPTH);

    logic [2*WORD_W-1:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic full;
    logic do_wr;
    logic do_rd;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == FULL_C);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues read requests and buffers returned words.
// Burst length is selected by FETCH_BURST_EN through mips_pkg.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'h0040_0000,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_address,
    output logic [1:0]        mem_access_size,
    output logic              mem_rw,
    input  logic              mem_busy,
    input  logic [WORD_W-1:0] mem_data_out,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_data,
    output logic [WORD_W-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [3:0]    LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [3:0]    BEAT_ONE  = 4'(1);

    fetch_state_e state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [CW-1:0] rsv_q, rsv_d;
    logic [3:0] beat_q, beat_d;
    logic started_q, started_d;

    logic [CW-1:0] fifo_count;
    logic [CW-1:0] avail;
    logic [2*WORD_W-1:0] fifo_head;
    logic fifo_empty;
    logic fifo_wr;
    logic issue;
    logic [1:0] unused_pc_bits;

    assign unused_pc_bits = redirect_pc[1:0];

    // Slots neither occupied nor promised to an outstanding burst.
    assign avail = DEPTH_C - fifo_count - rsv_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rsv_d     = rsv_q;
        beat_d    = beat_q;
        started_d = 1'b1;
        issue     = 1'b0;
        fifo_wr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (started_q && !mem_busy && !redirect_valid
                    && (avail >= BURST_C)) begin
                    issue   = 1'b1;
                    rsv_d   = rsv_q + BURST_C;
                    beat_d  = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (redirect_valid) begin
                    state_d = DRAIN;
                end else if (mem_busy) begin
                    fifo_wr = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    rsv_d   = rsv_q - ONE_C;
                    beat_d  = beat_q + BEAT_ONE;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!mem_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d  = {redirect_pc[WORD_W-1:2], 2'b00};
            rsv_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            rsv_q     <= '0;
            beat_q    <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsv_q     <= rsv_d;
            beat_q    <= beat_d;
            started_q <= started_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (redirect_valid),
        .wr_en   (fifo_wr),
        .wr_data ({pc_q, mem_data_out}),
        .rd_en   (inst_valid && inst_ready),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign mem_req         = issue;
    assign mem_address     = issue ? pc_q : '0;
    assign mem_access_size = issue ? FETCH_SIZE : ACC_1;
    assign mem_rw          = 1'b0;
    assign inst_valid      = !fifo_empty;
    assign inst_pc         = fifo_head[2*WORD_W-1:WORD_W];
    assign inst_data       = fifo_head[WORD_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus a stream-level reference model.
// Follows FETCH_BURST_EN to pick the expected burst length.
module tb_fetch_unit;

`ifdef FETCH_BURST_EN
    localparam int          N  = 4;
    localparam logic [1:0]  SZ = 2'b01;
`else
    localparam int          N  = 1;
    localparam logic [1:0]  SZ = 2'b00;
`endif
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          DEPTH  = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_data_out = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int vectors = 0;
    int miscompares = 0;
    int req_count = 0;
    int xfer_count = 0;
    int r0;
    logic [31:0] salt = 32'h1234_5678;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] next_req = RST_PC;
    logic        flush_chk = 1'b0;
    logic [31:0] xfer_pcs[$];
    int unsigned mem_left = 0;
    logic [31:0] mem_ptr = '0;

    fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .mem_req         (mem_req),
        .mem_address     (mem_address),
        .mem_access_size (mem_access_size),
        .mem_rw          (mem_rw),
        .mem_busy        (mem_busy),
        .mem_data_out    (mem_data_out),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [31:0] qpc(input int i);
        if (xfer_pcs.size() > i) return xfer_pcs[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input int max_cyc);
        bit found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clock);
            #1;
            if (mem_req) found = 1'b1;
        end
        chk("req_wait", 32'(found), 32'd1);
    endtask

    // Memory: busy exactly one cycle per word, starting the cycle after accept.
    always @(negedge clock) begin
        if (mem_left != 0) begin
            mem_busy     = 1'b1;
            mem_data_out = memfn(mem_ptr);
            mem_ptr      = mem_ptr + 32'd4;
            mem_left     = mem_left - 1;
        end else begin
            mem_busy     = 1'b0;
            mem_data_out = '0;
        end
        #2;
        if (mem_req) begin
            case (mem_access_size)
                2'b00:   mem_left = 1;
                2'b01:   mem_left = 4;
                2'b10:   mem_left = 8;
                default: mem_left = 16;
            endcase
            mem_ptr = mem_address;
        end
    end

    // Reference model: the delivered stream is consecutive words from the
    // last redirect target; requests walk forward by N words each.
    always @(negedge clock) begin
        #3;
        if (!reset_n) begin
            model_pc  = RST_PC;
            next_req  = RST_PC;
            flush_chk = 1'b0;
        end else begin
            if (flush_chk) chk("flush_valid", 32'(inst_valid), 32'd0);
            flush_chk = redirect_valid;
            if (redirect_valid) chk("req_redir", 32'(mem_req), 32'd0);
            if (mem_req) begin
                chk("req_addr", mem_address, next_req);
                chk("req_size", 32'(mem_access_size), 32'(SZ));
                chk("req_busy", 32'(mem_busy), 32'd0);
                next_req = next_req + 32'(4 * N);
                req_count++;
            end
            if (inst_valid && inst_ready) begin
                chk("inst_pc", inst_pc, model_pc);
                chk("inst_data", inst_data, memfn(model_pc));
                xfer_pcs.push_back(inst_pc);
                model_pc = model_pc + 32'd4;
                xfer_count++;
            end
            if (redirect_valid) begin
                model_pc = redirect_pc & 32'hFFFF_FFFC;
                next_req = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        salt           = $urandom;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_size", 32'(mem_access_size), 32'd0);
        chk("rst_rw", 32'(mem_rw), 32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("first_req_early", 32'(mem_req), 32'd0);
        @(negedge clock);
        #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_address, RST_PC);
        chk("first_size", 32'(mem_access_size), 32'(SZ));
        @(negedge clock);
        inst_ready = 1'b1;
        repeat (15) @(negedge clock);
        chk("boot_pc0", qpc(0), 32'h0040_0000);
        chk("boot_pc1", qpc(1), 32'h0040_0004);
        chk("boot_pc2", qpc(2), 32'h0040_0008);
        chk("boot_pc3", qpc(3), 32'h0040_000C);

        // Backpressure: buffer fills, then exactly one refill burst.
        @(negedge clock);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        @(negedge clock);
        redirect_valid = 1'b0;
        r0 = req_count;
        repeat (40) @(negedge clock);
        chk("bp_bursts", 32'(req_count - r0), 32'(DEPTH / N));
        chk("bp_valid", 32'(inst_valid), 32'd1);
        r0 = req_count;
        inst_ready = 1'b1;
        repeat (N) @(negedge clock);
        inst_ready = 1'b0;
        repeat (20) @(negedge clock);
        chk("bp_refill", 32'(req_count - r0), 32'd1);

        // Redirect during the second response word.
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        @(negedge clock);
        redirect_valid = 1'b0;
        wait_req(20);
        @(negedge clock);
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        xfer_pcs.delete();
        @(negedge clock);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (20) @(negedge clock);
        chk("redir_pc0", qpc(0), 32'h0000_1000);
        chk("redir_pc1", qpc(1), 32'h0000_1004);

        // Address wrap.
        @(negedge clock);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        xfer_pcs.delete();
        @(negedge clock);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (30) @(negedge clock);
        chk("wrap_pc0", qpc(0), 32'hFFFF_FFF8);
        chk("wrap_pc1", qpc(1), 32'hFFFF_FFFC);
        chk("wrap_pc2", qpc(2), 32'h0000_0000);
        chk("wrap_pc3", qpc(3), 32'h0000_0004);

        // Steady-state throughput with the consumer always ready.
        r0 = xfer_count;
        repeat (40) @(negedge clock);
        chk("rate", 32'(xfer_count - r0), 32'(40 * N / (N + 1)));

        // Reset in the middle of a burst.
        @(negedge clock);
        inst_ready = 1'b0;
        wait_req(20);
        @(negedge clock);
        @(negedge clock);
        chk("mid_valid", 32'(inst_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_addr", mem_address, 32'd0);
        chk("mid_rst_size", 32'(mem_access_size), 32'd0);
        @(negedge clock);
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        xfer_pcs.delete();
        #1;
        chk("mid_req_early", 32'(mem_req), 32'd0);
        repeat (20) @(negedge clock);
        chk("restart_pc0", qpc(0), RST_PC);
        chk("restart_pc1", qpc(1), RST_PC + 32'd4);

        // Random consumer stalls and redirects.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clock);
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 7) == 0)
                    redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else
                    redirect_pc = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
        end
        @(negedge clock);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (10) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
